// File: rtl/bicubic_upsample_mc.sv
// 4x bicubic upsampler: one 4x4 multi-channel window in, 16 sub-pixels out in raster order.
// Build option BICUBIC_UPSAMPLE_ROUND_EN selects round-half-up; otherwise the result is floored.
module bicubic_upsample_mc #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CH_NUM        = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              bf_req_valid,
  output logic                              bcci_req_ready,
  input  logic [16*CH_NUM*CHANNEL_WIDTH-1:0] bf_req_window,
  output logic                              bcci_rsp_valid,
  input  logic                              bf_rsp_ready,
  output logic [CH_NUM*CHANNEL_WIDTH-1:0]   bcci_rsp_data,
  output logic [3:0]                        bcci_rsp_phase,
  output logic                              bcci_rsp_last
);

  localparam int VW = CHANNEL_WIDTH + 9;
  localparam int HW = CHANNEL_WIDTH + 17;
  localparam int PW = CH_NUM * CHANNEL_WIDTH;
  localparam int WW = 16 * PW;

`ifdef BICUBIC_UPSAMPLE_ROUND_EN
  localparam logic signed [HW-1:0] RND = HW'(8192);
`else
  localparam logic signed [HW-1:0] RND = HW'(0);
`endif
  localparam logic signed [HW-1:0] SAT_MAX = HW'((1 << CHANNEL_WIDTH) - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              ph_p0, ph_nxt;
  logic [WW-1:0]           win_p0;
  logic                    adv, load, issue, ready;
  logic signed [VW-1:0]    v_p1 [CH_NUM][4];
  logic [3:0]              phase_p1;
  logic                    vld_p1;

  function automatic logic signed [8:0] weight(input logic [1:0] ph, input logic [1:0] tap);
    logic signed [8:0] w;
    case ({ph, tap})
      4'h1:    w = 9'sd128;
      4'h4:    w = -9'sd9;
      4'h5:    w = 9'sd111;
      4'h6:    w = 9'sd29;
      4'h7:    w = -9'sd3;
      4'h8:    w = -9'sd8;
      4'h9:    w = 9'sd72;
      4'hA:    w = 9'sd72;
      4'hB:    w = -9'sd8;
      4'hC:    w = -9'sd3;
      4'hD:    w = 9'sd29;
      4'hE:    w = 9'sd111;
      4'hF:    w = -9'sd9;
      default: w = 9'sd0;
    endcase
    return w;
  endfunction

  function automatic logic signed [VW-1:0] vert(input logic [1:0] i, input logic [WW-1:0] w,
                                                input int ch, input int c);
    logic signed [VW-1:0] acc;
    acc = '0;
    for (int r = 0; r < 4; r++)
      acc = acc + VW'(weight(i, 2'(r))) *
                  VW'($signed({1'b0, w[((r*4+c)*CH_NUM+ch)*CHANNEL_WIDTH +: CHANNEL_WIDTH]}));
    return acc;
  endfunction

  function automatic logic signed [HW-1:0] horiz(input logic [1:0] j, input logic signed [VW-1:0] v [4]);
    logic signed [HW-1:0] acc;
    acc = '0;
    for (int c = 0; c < 4; c++)
      acc = acc + HW'(weight(j, 2'(c))) * HW'(v[c]);
    return acc;
  endfunction

  // Weights sum to 128 per pass, so the combined gain of 2^14 is removed by the shift.
  function automatic logic [CHANNEL_WIDTH-1:0] round_sat(input logic signed [HW-1:0] h);
    logic signed [HW-1:0] s;
    s = (h + RND) >>> 14;
    if (s[HW-1])          return '0;
    else if (s > SAT_MAX) return '1;
    else                  return s[CHANNEL_WIDTH-1:0];
  endfunction

  assign adv            = !bcci_rsp_valid | bf_rsp_ready;
  assign bcci_req_ready = ready & rst_n;

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph_p0;
    ready     = 1'b0;
    load      = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        ready = adv;
        if (adv && bf_req_valid) begin
          load      = 1'b1;
          ph_nxt    = 4'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (adv) begin
          issue  = 1'b1;
          ph_nxt = ph_p0 + 4'd1;
          if (ph_p0 == 4'd15) begin
            ready = 1'b1;
            if (bf_req_valid) load = 1'b1;
            else              state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ph_p0 <= 4'd0;
    end else begin
      state <= state_nxt;
      ph_p0 <= ph_nxt;
    end
  end

  // Stage 0 -> 1: latch window, vertical pass for the issued row phase
  always_ff @(posedge clk) begin
    if (load) win_p0 <= bf_req_window;
    if (issue) begin
      for (int ch = 0; ch < CH_NUM; ch++)
        for (int c = 0; c < 4; c++)
          v_p1[ch][c] <= vert(ph_p0[3:2], win_p0, ch, c);
      phase_p1 <= ph_p0;
    end
  end

  // Stage 1 -> 2: horizontal pass, round, clamp into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1         <= 1'b0;
      bcci_rsp_valid <= 1'b0;
      bcci_rsp_data  <= '0;
      bcci_rsp_phase <= 4'd0;
      bcci_rsp_last  <= 1'b0;
    end else if (adv) begin
      vld_p1         <= issue;
      bcci_rsp_valid <= vld_p1;
      if (vld_p1) begin
        for (int ch = 0; ch < CH_NUM; ch++)
          bcci_rsp_data[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= round_sat(horiz(phase_p1[1:0], v_p1[ch]));
        bcci_rsp_phase <= phase_p1;
        bcci_rsp_last  <= (phase_p1 == 4'd15);
      end
    end
  end

endmodule

// File: tb/tb_bicubic_upsample_mc.sv
// Scoreboard bench for bicubic_upsample_mc: directed windows with hand-computed sub-pixel values.
module tb_bicubic_upsample_mc;
  localparam int CW = 8;
  localparam int CH = 3;
  localparam int PW = CW * CH;
  localparam int WW = 16 * PW;

  localparam int K_FLAT  = 0;
  localparam int K_HEDGE = 1;
  localparam int K_VEDGE = 2;
  localparam int K_HI    = 3;
  localparam int K_LO    = 4;
  localparam int K_RAND  = 5;

  // Row/column profile (0,0,255,255) through phases 0..3.
`ifdef BICUBIC_UPSAMPLE_ROUND_EN
  localparam logic [7:0] E1 = 8'd52;
  localparam logic [7:0] E2 = 8'd128;
`else
  localparam logic [7:0] E1 = 8'd51;
  localparam logic [7:0] E2 = 8'd127;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bf_req_valid = 1'b0;
  logic          bcci_req_ready;
  logic [WW-1:0] bf_req_window = '0;
  logic          bcci_rsp_valid;
  logic          bf_rsp_ready = 1'b1;
  logic [PW-1:0] bcci_rsp_data;
  logic [3:0]    bcci_rsp_phase;
  logic          bcci_rsp_last;

  bicubic_upsample_mc #(.CHANNEL_WIDTH(CW), .CH_NUM(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready), .bf_req_window(bf_req_window),
    .bcci_rsp_valid(bcci_rsp_valid), .bf_rsp_ready(bf_rsp_ready),
    .bcci_rsp_data(bcci_rsp_data), .bcci_rsp_phase(bcci_rsp_phase), .bcci_rsp_last(bcci_rsp_last)
  );

  typedef struct {
    logic [PW-1:0] data;
    logic          chk;
    logic [3:0]    phase;
  } exp_t;

  exp_t          sb [$];
  logic [PW-1:0] exp_pix [16];
  logic          exp_chk [16];
  logic [7:0]    edge_v [4];
  int            n_chk = 0, n_pass = 0, cyc = 0, hs_count = 0, last_hs_cyc = 0;
  logic          rand_on = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    bf_rsp_ready = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: handshakes pop the scoreboard; stalled outputs must hold.
  initial begin
    logic          stall_q;
    logic [29:0]   held;
    exp_t          e;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q)
          chk("stall_hold", {bcci_rsp_valid, bcci_rsp_last, bcci_rsp_phase, bcci_rsp_data}, {1'b1, held[28:0]});
        if (bcci_rsp_valid && bf_rsp_ready) begin
          stall_q = 1'b0;
          hs_count++;
          last_hs_cyc = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("phase", bcci_rsp_phase, e.phase);
            chk("last", bcci_rsp_last, e.phase == 4'd15);
            if (e.chk) chk("data", bcci_rsp_data, e.data);
          end
        end else if (bcci_rsp_valid) begin
          stall_q = 1'b1;
          held    = {bcci_rsp_valid, bcci_rsp_last, bcci_rsp_phase, bcci_rsp_data};
        end else begin
          stall_q = 1'b0;
        end
      end
    end
  end

  task automatic load(input int kind);
    logic [7:0] s, e;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        case (kind)
          K_FLAT:  s = 8'd100;
          K_HEDGE: s = (c >= 2) ? 8'd255 : 8'd0;
          K_VEDGE: s = (r >= 2) ? 8'd255 : 8'd0;
          K_HI:    s = (c == 1 || c == 2) ? 8'd255 : 8'd0;
          K_LO:    s = (c == 0 || c == 3) ? 8'd255 : 8'd0;
          default: s = 8'd0;
        endcase
        for (int ch = 0; ch < CH; ch++)
          bf_req_window[((r*4+c)*CH+ch)*CW +: CW] = (kind == K_RAND) ? 8'($urandom_range(0, 255)) : s;
      end
    for (int p = 0; p < 16; p++) begin
      case (kind)
        K_FLAT:  e = 8'd100;
        K_HEDGE: e = edge_v[p % 4];
        K_VEDGE: e = edge_v[p / 4];
        K_HI:    e = 8'd255;
        default: e = 8'd0;
      endcase
      exp_pix[p] = {CH{e}};
      exp_chk[p] = (kind != K_RAND);
    end
    if (kind == K_RAND) begin
      exp_pix[0] = bf_req_window[5*PW +: PW];
      exp_chk[0] = 1'b1;
    end
  endtask

  task automatic offer(input int kind, output int acc);
    exp_t e;
    load(kind);
    bf_req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bcci_req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        for (int p = 0; p < 16; p++) begin
          e.data  = exp_pix[p];
          e.chk   = exp_chk[p];
          e.phase = 4'(p);
          sb.push_back(e);
        end
        break;
      end
    end
    bf_req_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bcci_rsp_valid) break;
    end
    chk("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a, b, found;
    edge_v[0] = 8'd0;
    edge_v[1] = E1;
    edge_v[2] = E2;
    edge_v[3] = 8'd203;

    bf_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", bcci_rsp_valid, 0);
    chk("reset_data", bcci_rsp_data, 0);
    chk("reset_phase", bcci_rsp_phase, 0);
    chk("reset_last", bcci_rsp_last, 0);
    chk("reset_req_ready", bcci_req_ready, 0);
    @(posedge clk);
    #1;
    bf_req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    offer(K_FLAT, a);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bcci_rsp_valid) break;
    end
    chk("first_valid_latency", cyc - a, 2);
    drain();

    offer(K_RAND, a);  drain();
    offer(K_RAND, a);  drain();
    offer(K_HEDGE, a); drain();
    offer(K_VEDGE, a); drain();
    offer(K_HI, a);    drain();
    offer(K_LO, a);    drain();

    hs_count = 0;
    offer(K_VEDGE, a);
    offer(K_HEDGE, b);
    drain();
    chk("b2b_accept_spacing", b - a, 16);
    chk("b2b_output_count", hs_count, 32);
    chk("b2b_last_output_cycle", last_hs_cyc - a, 33);

    rand_on = 1'b1;
    offer(K_HEDGE, a);
    drain();

    offer(K_VEDGE, a);
    found = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bcci_rsp_valid && bcci_rsp_phase == 4'd7) begin found = 1; break; end
    end
    chk("reached_phase7", found, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rand_on = 1'b0;
    bf_req_valid = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midreset_valid", bcci_rsp_valid, 0);
    chk("midreset_data", bcci_rsp_data, 0);
    chk("midreset_phase", bcci_rsp_phase, 0);
    chk("midreset_last", bcci_rsp_last, 0);
    chk("midreset_req_ready", bcci_req_ready, 0);
    @(posedge clk);
    #1;
    bf_req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    offer(K_FLAT, a);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bicubic_upsample_mc.md
Name: bicubic_upsample_mc

Overview:
- Parametrised successor of the single-channel 4x bicubic upsampler.
- Accepts one 4x4 source window carrying CH_NUM channels and emits the 16 interpolated 4x sub-pixels in raster order, all channels in parallel.
- Uses a two-stage registered datapath with full valid/ready backpressure and zero-bubble back-to-back windows.
- Sits between the window buffer (bf_*) and the output packer.

Parameters:
- CHANNEL_WIDTH, 8: bits per channel sample.
- CH_NUM, 3: channels per pixel, all processed with identical weights.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- bf_req_valid  input  1  source window valid.
- bcci_req_ready  output  1  window accepted when valid & ready.
- bf_req_window  input  16*CH_NUM*CHANNEL_WIDTH  p[r][c], index (r*4+c), pixel-major, channel 0 at LSBs within each pixel.
- bcci_rsp_valid  output  1  output sub-pixel valid.
- bf_rsp_ready  input  1  downstream ready.
- bcci_rsp_data  output  CH_NUM*CHANNEL_WIDTH  interpolated pixel.
- bcci_rsp_phase  output  4  sub-pixel index i*4+j (i = row phase, j = column phase).
- bcci_rsp_last  output  1  high with phase 15.

Interface: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Weight sets W0..W3, signed, each summing to 128:
  - W0 = (0,128,0,0)
  - W1 = (-9,111,29,-3)
  - W2 = (-8,72,72,-8)
  - W3 = (-3,29,111,-9)
- Arithmetic, per channel, for phase (i,j):
  - Vertical pass: v_c = sum_r Wi[r]*p[r][c], signed, CHANNEL_WIDTH+9 bits, no rounding.
  - Horizontal pass: h = sum_c Wj[c]*v_c, signed, CHANNEL_WIDTH+17 bits.
  - Output: y = (h + RND) >>> 14, clamped to [0, 2^CHANNEL_WIDTH-1]. RND is set by the optional feature below.
- Registers:
  - Window register plus 4-bit phase counter ph.
  - Stage 1: registered v_0..v_3 plus phase, valid s1_v.
  - Stage 2: output register holding data, phase, last, valid = bcci_rsp_valid.
- Pipeline advance: adv = !bcci_rsp_valid | bf_rsp_ready. Every register updates only when adv.
- FSM:
  - IDLE: no window held. bcci_req_ready = adv. On accept, latch window, ph = 0, go to BUSY.
  - BUSY: each adv cycle, issue phase ph into stage 1 and ph++.
  - When ph == 15 is issued: bcci_req_ready = adv.
    - If a new window is accepted the same cycle: reload window, ph = 0, stay in BUSY (no bubble).
    - Otherwise go to IDLE.
  - bcci_req_ready = 0 in BUSY for ph < 15.
- Latency:
  - First output is valid 2 cycles after the accept edge, with no stall.
  - Sustained rate is 1 sub-pixel/cycle; 16 cycles per window.
- Backpressure: bcci_rsp_valid & !bf_rsp_ready freezes every stage. Output data, phase and last stay stable until the handshake.
- Reset, including mid-window: FSM returns to IDLE, ph = 0, s1_v = 0. All outputs reset to 0 (bcci_rsp_valid=0, bcci_rsp_data=0, bcci_rsp_phase=0, bcci_rsp_last=0). Partially emitted windows are discarded.
- bcci_req_ready is 0 throughout reset.
- Window contents are don't-care while bf_req_valid is low. The latched window is unaffected by input changes after accept.

Optional Feature:
- Macro BICUBIC_UPSAMPLE_ROUND_EN.
- Defined: RND = 8192, i.e. round-half-up before clamp.
- Undefined: RND = 0, i.e. floor (arithmetic shift truncation).
- Clamping is present in both builds.

Test Plan:
- Flat window, all samples 100, CH_NUM=3, bf_rsp_ready=1 -> 16 outputs of 100 on every channel, phases 0..15 in order. bcci_rsp_last on phase 15 only. First valid 2 cycles after accept.
- Phase 0 pass-through: random window -> output at phase 0 equals p[1][1] exactly, per channel.
- Horizontal edge with every row = (0,0,255,255), phase 1 -> 52 with BICUBIC_UPSAMPLE_ROUND_EN, 51 without.
- Clamp with rows = (0,255,255,0): phase 1 -> 255 (unclamped 278.9). Rows = (255,0,0,255): phase 1 -> 0.
- Two windows offered back-to-back with bf_rsp_ready=1 -> 32 consecutive valid cycles with no gap. bcci_req_ready pulses only during the phase-15 issue cycle.
- Random bf_rsp_ready toggling, then rst_n asserted at phase 7 -> outputs stable during stalls. After reset, valid=0 and data/phase/last=0. The next accepted window restarts at phase 0.
